// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Sequential issue/writeback controller for the ALU. It takes
//            CR16-style instruction words over a valid/ready handshake and
//            decodes each one to the ALU opcode. It fetches operands from the
//            external register file, presents them to the ALU for one cycle,
//            then writes the result back and latches the flags into the PSR.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            instr, instr_valid/ready    - instruction handshake
//            rf_raddr_a/b, rf_rdata_a/b  - register-file read ports
//            alu_opcode/rdest/rsrc       - ALU operands (valid in EXEC only)
//            alu_out, alu_flags          - ALU results
//            rf_we, rf_waddr, rf_wdata   - register-file write port
//            psr                         - status {C,L,F,Z,N}
//            illegal                     - pulse on undecodable word
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int OPC_W  = 5,
    parameter int RA_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [RA_W-1:0]   rf_raddr_a,
    output logic [RA_W-1:0]   rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_rdest,
    output logic [DATA_W-1:0] alu_rsrc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [4:0]        alu_flags,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [4:0]        psr,
    output logic              illegal
);

    localparam logic [OPC_W-1:0] c_OPC_ADD    = 5'b00000;
    localparam logic [OPC_W-1:0] c_OPC_ADDI   = 5'b00001;
    localparam logic [OPC_W-1:0] c_OPC_ADDU   = 5'b00010;
    localparam logic [OPC_W-1:0] c_OPC_ADDUI  = 5'b00011;
    localparam logic [OPC_W-1:0] c_OPC_ADDC   = 5'b00100;
    localparam logic [OPC_W-1:0] c_OPC_ADDCU  = 5'b00101;
    localparam logic [OPC_W-1:0] c_OPC_ADDCUI = 5'b00110;
    localparam logic [OPC_W-1:0] c_OPC_ADDCI  = 5'b00111;
    localparam logic [OPC_W-1:0] c_OPC_SUB    = 5'b01000;
    localparam logic [OPC_W-1:0] c_OPC_SUBI   = 5'b01001;
    localparam logic [OPC_W-1:0] c_OPC_CMP    = 5'b01010;
    localparam logic [OPC_W-1:0] c_OPC_CMPI   = 5'b01011;
    localparam logic [OPC_W-1:0] c_OPC_CMPUI  = 5'b01100;
    localparam logic [OPC_W-1:0] c_OPC_AND    = 5'b01101;
    localparam logic [OPC_W-1:0] c_OPC_OR     = 5'b01110;
    localparam logic [OPC_W-1:0] c_OPC_XOR    = 5'b01111;
    localparam logic [OPC_W-1:0] c_OPC_NOT    = 5'b10000;
    localparam logic [OPC_W-1:0] c_OPC_LSH    = 5'b10001;
    localparam logic [OPC_W-1:0] c_OPC_LSHI   = 5'b10010;
    localparam logic [OPC_W-1:0] c_OPC_RSH    = 5'b10011;
    localparam logic [OPC_W-1:0] c_OPC_RSHI   = 5'b10100;
    localparam logic [OPC_W-1:0] c_OPC_ALSH   = 5'b10101;
    localparam logic [OPC_W-1:0] c_OPC_ARSH   = 5'b10110;
    localparam logic [OPC_W-1:0] c_OPC_NOP    = 5'b10111;

    // Second-operand source
    localparam logic [1:0] c_SEL_REG  = 2'd0;  // Rsrc register
    localparam logic [1:0] c_SEL_SEXT = 2'd1;  // sign-extended imm8
    localparam logic [1:0] c_SEL_ZEXT = 2'd2;  // zero-extended imm8
    localparam logic [1:0] c_SEL_IMM4 = 2'd3;  // zero-extended shift amount

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t             r_state;
    logic [15:0]        r_ir;
    logic               r_wr;       // instruction writes Rdest
    logic               r_upd;      // instruction updates psr
    logic [4:0]         r_flags;

    logic               w_legal;
    logic [OPC_W-1:0]   w_opc;
    logic [1:0]         w_sel;
    logic               w_wr;
    logic               w_upd;
    logic [DATA_W-1:0]  w_operand;

    // Read addresses come straight from the instruction register, so they
    // are stable for the whole DECODE cycle.
    assign rf_raddr_a = r_ir[11:8];
    assign rf_raddr_b = r_ir[3:0];

    always_comb begin
        w_legal = 1'b1;
        w_opc   = c_OPC_NOP;
        w_sel   = c_SEL_REG;
        w_wr    = 1'b1;
        w_upd   = 1'b1;
        case (r_ir[15:12])
            4'h0: begin
                case (r_ir[7:4])
                    4'h5: w_opc = c_OPC_ADD;
                    4'h6: w_opc = c_OPC_ADDU;
                    4'h7: w_opc = c_OPC_ADDC;
                    4'h4: w_opc = c_OPC_ADDCU;
                    4'h9: w_opc = c_OPC_SUB;
                    4'hB: begin w_opc = c_OPC_CMP; w_wr = 1'b0; end
                    4'h1: w_opc = c_OPC_AND;
                    4'h2: w_opc = c_OPC_OR;
                    4'h3: w_opc = c_OPC_XOR;
                    4'hF: w_opc = c_OPC_NOT;
                    4'h0: begin w_opc = c_OPC_NOP; w_wr = 1'b0; w_upd = 1'b0; end
                    default: w_legal = 1'b0;
                endcase
            end
            4'h5: begin w_opc = c_OPC_ADDI;   w_sel = c_SEL_SEXT; end
            4'h6: begin w_opc = c_OPC_ADDUI;  w_sel = c_SEL_ZEXT; end
            4'h7: begin w_opc = c_OPC_ADDCI;  w_sel = c_SEL_SEXT; end
            4'h4: begin w_opc = c_OPC_ADDCUI; w_sel = c_SEL_ZEXT; end
            4'h9: begin w_opc = c_OPC_SUBI;   w_sel = c_SEL_SEXT; end
            4'hB: begin w_opc = c_OPC_CMPI;   w_sel = c_SEL_SEXT; w_wr = 1'b0; end
            4'hC: begin w_opc = c_OPC_CMPUI;  w_sel = c_SEL_ZEXT; w_wr = 1'b0; end
            4'h8: begin
                case (r_ir[7:4])
                    4'h4: w_opc = c_OPC_LSH;
                    4'h6: w_opc = c_OPC_RSH;
                    4'h5: w_opc = c_OPC_ALSH;
                    4'h7: w_opc = c_OPC_ARSH;
                    4'h0: begin w_opc = c_OPC_LSHI; w_sel = c_SEL_IMM4; end
                    4'h1: begin w_opc = c_OPC_RSHI; w_sel = c_SEL_IMM4; end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (w_sel)
            c_SEL_SEXT: w_operand = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
            c_SEL_ZEXT: w_operand = {{(DATA_W-8){1'b0}}, r_ir[7:0]};
            c_SEL_IMM4: w_operand = {{(DATA_W-4){1'b0}}, r_ir[3:0]};
            default:    w_operand = rf_rdata_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_wr        <= 1'b0;
            r_upd       <= 1'b0;
            r_flags     <= '0;
            instr_ready <= 1'b0;
            alu_opcode  <= '0;
            alu_rdest   <= '0;
            alu_rsrc    <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            psr         <= '0;
            illegal     <= 1'b0;
        end else begin
            // ALU inputs idle at NOP/0 except during EXEC; strobes are
            // single-cycle unless re-asserted below.
            rf_we      <= 1'b0;
            illegal    <= 1'b0;
            alu_opcode <= c_OPC_NOP;
            alu_rdest  <= '0;
            alu_rsrc   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        r_ir        <= instr;
                        instr_ready <= 1'b0;
                        r_state     <= S_DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        illegal     <= 1'b1;
                        instr_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        // These registers hold the ALU inputs for all of EXEC
                        alu_opcode <= w_opc;
                        alu_rdest  <= rf_rdata_a;
                        alu_rsrc   <= w_operand;
                        r_wr       <= w_wr;
                        r_upd      <= w_upd;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rf_wdata <= alu_out;
                    rf_waddr <= r_ir[11:8];
                    rf_we    <= r_wr;
                    r_flags  <= alu_flags;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    if (r_upd) begin
                        psr <= r_flags;
                    end
                    // Raised here so the next word is taken on the edge that
                    // returns to IDLE's successor: one word per four cycles.
                    instr_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl with a behavioural
//            register file and ALU, plus a write-back scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, alu_rdest, alu_rsrc, alu_out, rf_wdata;
    logic [4:0]  alu_opcode, alu_flags, psr;
    logic        rf_we, illegal;

    localparam logic [4:0] c_NOP = 5'b10111;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_opcode(alu_opcode), .alu_rdest(alu_rdest), .alu_rsrc(alu_rsrc),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .psr(psr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Environment: register file written by the DUT, and a simple ALU
    logic [15:0] rf [16];
    logic [15:0] mrf [16];
    logic [4:0]  mpsr = '0;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    assign alu_out    = (alu_rdest + alu_rsrc) ^ {11'd0, alu_opcode};
    assign alu_flags  = alu_rdest[4:0] ^ alu_rsrc[4:0] ^ alu_opcode;

    always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t q[$];

    always @(negedge clk) begin
        wr_t e;
        if (rst_n && rf_we) begin
            if (q.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                e = q.pop_front();
                check("waddr", rf_waddr, e.a);
                check("wdata", rf_wdata, e.d);
            end
        end
    end

    // Expected decode of the word most recently predicted
    logic        e_legal, e_wr, e_upd;
    logic [4:0]  e_opc;
    logic [1:0]  e_sel;
    logic [15:0] e_a, e_b;

    task automatic predict(input logic [15:0] w);
        logic [3:0]  op, ext;
        logic [15:0] res;
        logic [4:0]  fl;
        op = w[15:12];
        ext = w[7:4];
        e_legal = 1'b1; e_wr = 1'b1; e_upd = 1'b1; e_sel = 2'd0; e_opc = c_NOP;
        case (op)
            4'h0: case (ext)
                4'h5: e_opc = 5'd0;
                4'h6: e_opc = 5'd2;
                4'h7: e_opc = 5'd4;
                4'h4: e_opc = 5'd5;
                4'h9: e_opc = 5'd8;
                4'hB: begin e_opc = 5'd10; e_wr = 1'b0; end
                4'h1: e_opc = 5'd13;
                4'h2: e_opc = 5'd14;
                4'h3: e_opc = 5'd15;
                4'hF: e_opc = 5'd16;
                4'h0: begin e_opc = 5'd23; e_wr = 1'b0; e_upd = 1'b0; end
                default: e_legal = 1'b0;
            endcase
            4'h5: begin e_opc = 5'd1;  e_sel = 2'd1; end
            4'h6: begin e_opc = 5'd3;  e_sel = 2'd2; end
            4'h7: begin e_opc = 5'd7;  e_sel = 2'd1; end
            4'h4: begin e_opc = 5'd6;  e_sel = 2'd2; end
            4'h9: begin e_opc = 5'd9;  e_sel = 2'd1; end
            4'hB: begin e_opc = 5'd11; e_sel = 2'd1; e_wr = 1'b0; end
            4'hC: begin e_opc = 5'd12; e_sel = 2'd2; e_wr = 1'b0; end
            4'h8: case (ext)
                4'h4: e_opc = 5'd17;
                4'h6: e_opc = 5'd19;
                4'h5: e_opc = 5'd21;
                4'h7: e_opc = 5'd22;
                4'h0: begin e_opc = 5'd18; e_sel = 2'd3; end
                4'h1: begin e_opc = 5'd20; e_sel = 2'd3; end
                default: e_legal = 1'b0;
            endcase
            default: e_legal = 1'b0;
        endcase
        e_a = mrf[w[11:8]];
        case (e_sel)
            2'd1:    e_b = {{8{w[7]}}, w[7:0]};
            2'd2:    e_b = {8'h00, w[7:0]};
            2'd3:    e_b = {12'h000, w[3:0]};
            default: e_b = mrf[w[3:0]];
        endcase
        if (e_legal) begin
            res = (e_a + e_b) ^ {11'd0, e_opc};
            fl  = e_a[4:0] ^ e_b[4:0] ^ e_opc;
            if (e_wr) begin
                q.push_back('{a: w[11:8], d: res});
                mrf[w[11:8]] = res;
            end
            if (e_upd) mpsr = fl;
        end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (instr_ready) ok = 1'b1;
            else @(negedge clk);
        end
        check("ready_timeout", ok, 1);
    endtask

    task automatic issue(input logic [15:0] w);
        predict(w);
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);                         // DECODE
        check("raddr_a", rf_raddr_a, w[11:8]);
        check("raddr_b", rf_raddr_b, w[3:0]);
        @(negedge clk);
        if (!e_legal) begin
            check("illegal_pulse", illegal, 1);
            check("illegal_ready", instr_ready, 1);
            check("illegal_no_we", rf_we, 0);
            check("illegal_psr", psr, mpsr);
            @(negedge clk);
            check("illegal_end", illegal, 0);
        end else begin                          // EXEC
            check("exec_opcode", alu_opcode, e_opc);
            check("exec_rdest", alu_rdest, e_a);
            check("exec_rsrc", alu_rsrc, e_b);
            check("exec_illegal", illegal, 0);
            @(negedge clk);                     // WB
            check("wb_opcode_nop", alu_opcode, c_NOP);
            check("wb_rsrc_zero", alu_rsrc, 0);
            check("wb_we", rf_we, e_wr);
            @(negedge clk);                     // IDLE
            check("psr", psr, mpsr);
            check("ready_after", instr_ready, 1);
            check("we_one_cycle", rf_we, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops [8];
        logic [15:0] w;
        time         t1, t2;
        ops = '{4'h0, 4'h0, 4'h5, 4'h6, 4'h8, 4'h8, 4'hC, 4'hF};
        for (int i = 0; i < 16; i++) begin
            rf[i]  = 16'($urandom);
            mrf[i] = rf[i];
        end
        rf[3] = 16'h0010; mrf[3] = 16'h0010;
        rf[5] = 16'h0020; mrf[5] = 16'h0020;
        rf[1] = 16'h0000; mrf[1] = 16'h0000;
        rf[2] = 16'h0002; mrf[2] = 16'h0002;

        repeat (2) @(negedge clk);
        check("rst_ready", instr_ready, 0);
        check("rst_we", rf_we, 0);
        check("rst_opcode", alu_opcode, 0);
        check("rst_psr", psr, 0);
        check("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", instr_ready, 1);
        check("idle_opcode", alu_opcode, c_NOP);

        issue(16'h01B2);                        // CMP R1,R2
        check("cmp_psr", psr, 5'b01000);
        issue(16'h0355);                        // ADD R3,R5 -> 0x0030
        check("add_result", rf[3], 16'h0030);
        issue(16'h52FF);                        // ADDI sign-extended
        issue(16'h62FF);                        // ADDUI zero-extended
        issue(16'hF000);                        // illegal
        issue(16'h0000);                        // NOP
        issue(16'h8403);                        // LSHI
        issue(16'h8472);                        // ARSH
        issue(16'h08A1);                        // illegal ext under op 0000
        for (int i = 0; i < 12; i++) begin
            w = 16'($urandom);
            w[15:12] = ops[$urandom_range(0, 7)];
            issue(w);
        end

        // Back-to-back: second word reads the register the first one writes
        predict(16'h0A55);
        predict(16'h0B5A);
        @(negedge clk);
        instr = 16'h0A55;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        t1 = $time;
        #1 instr = 16'h0B5A;
        @(negedge clk);
        wait_ready();
        @(posedge clk);
        t2 = $time;
        #1 instr_valid = 1'b0;
        check("b2b_gap_edges", 32'((t2 - t1) / 10), 4);
        repeat (5) @(negedge clk);
        check("b2b_psr", psr, mpsr);
        check("b2b_sb_empty", q.size(), 0);

        // Reset during EXEC abandons the instruction
        @(negedge clk);
        instr = 16'h0355;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);                         // now in EXEC
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", instr_ready, 0);
        check("mid_rst_opcode", alu_opcode, 0);
        check("mid_rst_rdest", alu_rdest, 0);
        check("mid_rst_rsrc", alu_rsrc, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_psr", psr, 0);
        mpsr = '0;
        repeat (2) @(negedge clk);
        check("mid_rst_hold", instr_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_release", instr_ready, 1);
        repeat (4) @(negedge clk);

        issue(16'h0355);                        // works again after reset
        check("sb_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
